// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared op encodings, controller states and width defaults for the RAM front end
package ram_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAP,
    ST_RD_RESP,
    ST_FILL,
    ST_CLR
  } ctrl_state_t;

endpackage

// File: rtl/ram_sp.sv
// rtl/ram_sp.sv - 16x8 single-port RAM, synchronous active-high reset, registered read port
module ram_sp #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] datain,
  output logic [DW-1:0] dataout
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
      dataout <= '0;
    end else begin
      if (we) mem_q[addr] <= datain;
      dataout <= mem_q[addr];
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - command front end for the single-port RAM: init sequencing, write/read/fill/clear
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int INIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          ram_rst,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] INIT_LAST = (AW+1)'(INIT_CYCLES - 1);
  localparam logic [AW:0] FILL_LAST = (AW+1)'(DEPTH);

  ctrl_state_t   state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;       // INIT cycle count, then fill address
  logic          ram_rst_q, ram_rst_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ram_rst_q   <= 1'b1;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_rst_q   <= ram_rst_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_rst_d   = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          ram_rst_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_WR: begin
              ram_we_d   = 1'b1;
              ram_addr_d = cmd_addr;
              ram_din_d  = cmd_data;
            end
            OP_RD: begin
              ram_addr_d = cmd_addr;
              state_d    = ST_RD_ISSUE;
            end
            OP_FILL: begin
              ram_din_d = cmd_data;
              cnt_d     = '0;
              state_d   = ST_FILL;
            end
            default: begin
              ram_rst_d = 1'b1;
              state_d   = ST_CLR;
            end
          endcase
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAP;
      // RAM output register now holds the addressed word
      ST_RD_CAP: begin
        rsp_data_d  = ram_dout;
        rsp_valid_d = 1'b1;
        state_d     = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (cnt_q == FILL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = cnt_q[AW-1:0];
          cnt_d      = cnt_q + 1'b1;
        end
      end
      ST_CLR:  state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign ram_rst   = ram_rst_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Command front end for the 16x8 single-port RAM (synchronous active-high `rst`, `we`, `addr`, `datain`, `dataout`).
- Sequences the RAM's synchronous reset after power-up.
- Accepts write, read, fill and clear commands over a valid/ready interface and drives the RAM port from registers.
- Handles the RAM's registered read latency and returns read data over a valid/ready response channel.

Parameters:
- AW, 4, RAM address width; DEPTH = 2**AW.
- DW, 8, RAM data width.
- INIT_CYCLES, 2, number of clocks `ram_rst` stays high after reset release (minimum 1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 write, 01 read, 10 fill, 11 clear.
- cmd_addr  in  AW  address for write/read; ignored for fill/clear.
- cmd_data  in  DW  write data or fill pattern.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts read data.
- rsp_data  out  DW  read data.
- busy  out  1  high whenever state is not IDLE.
- ram_rst  out  1  to RAM `rst` (sync, active-high).
- ram_we  out  1  to RAM `we`.
- ram_addr  out  AW  to RAM `addr`.
- ram_din  out  DW  to RAM `datain`.
- ram_dout  in  DW  from RAM `dataout`.

Behaviour:
- All outputs are registered, except `cmd_ready` and `busy`, which decode from the state register.
- Reset (`rst` = 0, asynchronous):
  - state = INIT, `ram_rst` = 1, `ram_we` = 0, `ram_addr` = 0, `ram_din` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `cmd_ready` = 0, `busy` = 1.
  - Any command in flight is dropped; a pending response is lost.
- States: INIT, IDLE, RD_ISSUE, RD_CAP, RD_RESP, FILL, CLR.
- INIT:
  - `ram_rst` held high for INIT_CYCLES rising edges after `rst` deasserts.
  - Then `ram_rst` = 0, go to IDLE.
- IDLE: `cmd_ready` = 1. A command is accepted on the edge where `cmd_valid` & `cmd_ready` are both high.
- Write (op 00):
  - Accepted at edge E0: `ram_we` = 1, `ram_addr` = `cmd_addr`, `ram_din` = `cmd_data`. The RAM writes at E1.
  - State stays IDLE, so back-to-back writes are allowed, one per cycle.
  - `ram_we` drops to 0 at E1 unless another write is accepted at E1.
- Read (op 01):
  - Accepted at E0: `ram_we` = 0, `ram_addr` = `cmd_addr`; go to RD_ISSUE.
  - E1: the RAM registers `dataout`; go to RD_CAP.
  - E2: `rsp_data` captures `ram_dout`, `rsp_valid` = 1; go to RD_RESP.
  - Read latency is 2 clocks from acceptance.
  - RD_RESP: hold `rsp_valid` and `rsp_data` stable until `rsp_valid` & `rsp_ready`. On that edge `rsp_valid` = 0 and state returns to IDLE.
  - Only one read is outstanding at a time. `cmd_ready` = 0 from E0 until the next cycle after response acceptance.
  - `rsp_ready` is ignored while `rsp_valid` = 0.
- Read-after-write:
  - A write accepted at E0 followed by a read of the same address at E1 returns the new data, because the RAM writes at E1 and reads at E2.
- Fill (op 10):
  - Go to FILL with a counter = 0.
  - Each cycle: `ram_we` = 1, `ram_addr` = counter, `ram_din` = `cmd_data` (latched at acceptance).
  - After DEPTH writes (addresses 0..DEPTH-1, no wrap), `ram_we` = 0 and state returns to IDLE.
  - The fill occupies DEPTH+1 cycles with `busy` = 1.
- Clear (op 11):
  - Go to CLR; `ram_rst` = 1 for exactly one cycle, then IDLE with `ram_rst` = 0.
  - The RAM zeros all locations and `dataout` on that edge.
- `ram_we` and `ram_rst` are never both 1.
- `ram_we` = 0 in INIT, RD_*, and CLR.
- `cmd_*` inputs are don't-care while `cmd_ready` = 0.
- `rst` asserted mid-fill or mid-read: immediately return to the reset values and re-run INIT.

Decomposition:
- Shared package `ram_pkg`:
  - op encodings OP_WR/OP_RD/OP_FILL/OP_CLR.
  - state enum `ctrl_state_t`.
  - AW/DW defaults.
- No sub-module; the fill counter and INIT counter share one AW+1-bit counter register.
- The testbench instantiates `ram_ctrl` plus the RAM together.

Test Plan:
- Reset release with INIT_CYCLES = 2 -> `ram_rst` = 1 for 2 edges after `rst` rises; `cmd_ready` = 1 on the third cycle; `busy` = 0.
- Write addr 3 = 0xA5, addr 7 = 0x3C back-to-back, then read addr 3 and read addr 7 -> `rsp_data` 0xA5 and 0x3C, each with `rsp_valid` rising 2 clocks after acceptance.
- Read addr 3 with `rsp_ready` held low 5 cycles -> `rsp_valid`/`rsp_data` = 0xA5 stable for 5 cycles, `cmd_ready` = 0 throughout; IDLE the cycle after handshake.
- Write addr 9 = 0x11 at E0, read addr 9 accepted at E1 -> `rsp_data` = 0x11 (read-after-write).
- Fill 0x5A -> `ram_we` high 16 consecutive cycles with addresses 0..15; reads of addr 0 and addr 15 return 0x5A. Then clear -> one-cycle `ram_rst`, and reads of addr 0 and addr 15 return 0x00.
- Assert `rst` low at fill address 6 -> `ram_we` = 0 immediately; INIT re-runs; locations 0..5 are cleared by the INIT `ram_rst`, and a read returns 0x00.
